// File: rtl/mips_pkg.sv
// mips_pkg: encodings shared across the MIPS pipeline slice.
//   MTR_*    : writeback source select values carried on MemtoReg.
//   REG_ZERO : architectural zero register index.
package mips_pkg;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_mux.sv
// wb_mux: writeback source selection for the register file.
// Ports:
//   pc_plus4   in  return address for link writes
//   mem_data   in  load data
//   alu_out    in  ALU result
//   memtoreg   in  source select (MTR_* from mips_pkg)
//   write_data out selected writeback value
module wb_mux
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [1:0]        memtoreg,
    output logic [DATA_W-1:0] write_data
);

    // Encoding 11 is unused and falls back to the ALU result; a plain case
    // keeps X on memtoreg harmless while no write is pending.
    always_comb begin
        write_data = alu_out;
        case (memtoreg)
            MTR_MEM: write_data = mem_data;
            MTR_PC4: write_data = pc_plus4;
            default: write_data = alu_out;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS writeback stage plus two-read/one-write register file.
// Build option: define WB_BYPASS_EN to forward the in-flight writeback value
// to a read port whose address matches the destination register.
// Ports:
//   clk                  in  clock, rising edge
//   reset                in  asynchronous reset, active low
//   WB_PCplus4           in  return address for link writes
//   WB_Memory_Read_Data  in  load data
//   WB_ALU_out           in  ALU result
//   WB_Write_register    in  destination register
//   WB_RegWrite          in  write enable
//   WB_MemtoReg          in  writeback source select
//   ID_Read_register1/2  in  read addresses
//   ID_Read_data1/2      out read data (combinational)
//   WB_Write_data        out selected writeback value (to forwarding unit)
//   WB_Retire_count      out number of committed register writes (wraps)
module wb_regfile
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] WB_PCplus4,
    input  logic [DATA_W-1:0] WB_Memory_Read_Data,
    input  logic [DATA_W-1:0] WB_ALU_out,
    input  logic [4:0]        WB_Write_register,
    input  logic              WB_RegWrite,
    input  logic [1:0]        WB_MemtoReg,
    input  logic [4:0]        ID_Read_register1,
    input  logic [4:0]        ID_Read_register2,
    output logic [DATA_W-1:0] ID_Read_data1,
    output logic [DATA_W-1:0] ID_Read_data2,
    output logic [DATA_W-1:0] WB_Write_data,
    output logic [31:0]       WB_Retire_count
);

    localparam logic [5:0] NREGS_L = 6'(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [31:0]       retire_q;
    logic [31:0]       retire_d;
    logic              wr_en;

    // Non-zero and inside the implemented array.
    function automatic logic addr_ok(input logic [4:0] a);
        return (a != REG_ZERO) && ({1'b0, a} < NREGS_L);
    endfunction

    wb_mux #(
        .DATA_W (DATA_W)
    ) u_wb_mux (
        .pc_plus4   (WB_PCplus4),
        .mem_data   (WB_Memory_Read_Data),
        .alu_out    (WB_ALU_out),
        .memtoreg   (WB_MemtoReg),
        .write_data (WB_Write_data)
    );

    assign wr_en = WB_RegWrite && addr_ok(WB_Write_register);

    always_comb begin
        retire_d = retire_q;
        if (wr_en) begin
            retire_d = retire_q + 32'd1;
        end
    end

    // Reset branch has priority, so an edge seen while reset is low never writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            retire_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[WB_Write_register] <= WB_Write_data;
            end
            retire_q <= retire_d;
        end
    end

    assign WB_Retire_count = retire_q;

    // Reads are forced to zero while reset is held, which also masks any
    // bypassed value during that window.
    always_comb begin
        ID_Read_data1 = '0;
        ID_Read_data2 = '0;
        if (reset) begin
            if (addr_ok(ID_Read_register1)) begin
                ID_Read_data1 = regs_q[ID_Read_register1];
            end
            if (addr_ok(ID_Read_register2)) begin
                ID_Read_data2 = regs_q[ID_Read_register2];
            end
`ifdef WB_BYPASS_EN
            if (wr_en && (ID_Read_register1 == WB_Write_register)) begin
                ID_Read_data1 = WB_Write_data;
            end
            if (wr_en && (ID_Read_register2 == WB_Write_register)) begin
                ID_Read_data2 = WB_Write_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
`timescale 1ns/100ps
module tb_wb_regfile;

    localparam logic [1:0] SelRd1 = 2'd0;
    localparam logic [1:0] SelRd2 = 2'd1;
    localparam logic [1:0] SelWd  = 2'd2;
    localparam logic [1:0] SelCnt = 2'd3;

    typedef struct {
        string       name;
        logic [1:0]  sel;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc4, mem, alu;
    logic [4:0]  wreg, ra1, ra2;
    logic        regwrite;
    logic [1:0]  mtr;
    logic [31:0] rd1, rd2, wdata, cnt;

    exp_t exp_q[$];
    event sample;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk                 (clk),
        .reset               (reset),
        .WB_PCplus4          (pc4),
        .WB_Memory_Read_Data (mem),
        .WB_ALU_out          (alu),
        .WB_Write_register   (wreg),
        .WB_RegWrite         (regwrite),
        .WB_MemtoReg         (mtr),
        .ID_Read_register1   (ra1),
        .ID_Read_register2   (ra2),
        .ID_Read_data1       (rd1),
        .ID_Read_data2       (rd2),
        .WB_Write_data       (wdata),
        .WB_Retire_count     (cnt)
    );

    // Monitor: drains every queued expectation when the stimulus strobes.
    always @(sample) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.sel)
                SelRd1:  act = rd1;
                SelRd2:  act = rd2;
                SelWd:   act = wdata;
                default: act = cnt;
            endcase
            n_checks++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.val, $time);
            end
        end
    end

    task automatic expect_val(input string name, input logic [1:0] sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Strobe the monitor and step 1ns so it has drained before inputs move.
    task automatic strobe();
        -> sample;
        #1;
    endtask

    // Advance past the next rising edge; inputs are then changed 2ns after it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_wr(input logic we, input logic [4:0] dst, input logic [1:0] sel,
                          input logic [31:0] a);
        regwrite = we;
        wreg     = dst;
        mtr      = sel;
        alu      = a;
    endtask

    logic [31:0] byp_exp;

    initial begin
        reset = 1'b0;
        pc4 = 32'h33; mem = 32'h22; alu = 32'h11;
        wreg = 5'd0; regwrite = 1'b0; mtr = 2'b00; ra1 = 5'd5; ra2 = 5'd0;
        #2;
        expect_val("reset_rd1_r5", SelRd1, 32'h0);
        expect_val("reset_rd2_r0", SelRd2, 32'h0);
        expect_val("reset_cnt", SelCnt, 32'h0);
        strobe();
        tick();
        reset = 1'b1;

        // Source select sweep into reg5; first write lands on first edge after reset.
        ra1 = 5'd5; ra2 = 5'd5;
        set_wr(1'b1, 5'd5, 2'b00, 32'h11);
        expect_val("wdata_mtr00", SelWd, 32'h11);
        strobe();
        tick();
        expect_val("r5_mtr00", SelRd1, 32'h11);
        expect_val("cnt_after1", SelCnt, 32'd1);
        mtr = 2'b01;
        expect_val("wdata_mtr01", SelWd, 32'h22);
        strobe();
        tick();
        expect_val("r5_mtr01", SelRd1, 32'h22);
        mtr = 2'b10;
        strobe();
        tick();
        expect_val("r5_mtr10", SelRd1, 32'h33);
        expect_val("r5_mtr10_p2", SelRd2, 32'h33);
        mtr = 2'b11;
        strobe();
        tick();
        expect_val("r5_mtr11", SelRd1, 32'h11);
        expect_val("cnt_after4", SelCnt, 32'd4);
        strobe();

        // Writes to register 0 are dropped and not counted.
        set_wr(1'b1, 5'd0, 2'b00, 32'hDEADBEEF);
        ra1 = 5'd0;
        tick();
        regwrite = 1'b0;
        expect_val("r0_reads_zero", SelRd1, 32'h0);
        expect_val("r0_cnt_same", SelCnt, 32'd4);
        strobe();

        // RegWrite gating with an undefined source select.
        set_wr(1'b1, 5'd9, 2'b00, 32'h99);
        tick();
        set_wr(1'b0, 5'd9, 2'bxx, 32'h1234);
        repeat (10) tick();
        ra1 = 5'd9;
        expect_val("r9_gated", SelRd1, 32'h99);
        expect_val("cnt_gated", SelCnt, 32'd5);
        strobe();

        // Bypass: reg7 holds 0x77, then 0xCAFE is written while both ports read 7.
        set_wr(1'b1, 5'd7, 2'b00, 32'h77);
        tick();
        ra1 = 5'd7; ra2 = 5'd7;
        set_wr(1'b1, 5'd7, 2'b00, 32'hCAFE);
`ifdef WB_BYPASS_EN
        byp_exp = 32'hCAFE;
`else
        byp_exp = 32'h77;
`endif
        expect_val("byp_same_rd1", SelRd1, byp_exp);
        expect_val("byp_same_rd2", SelRd2, byp_exp);
        strobe();
        tick();
        regwrite = 1'b0;
        expect_val("byp_next_rd1", SelRd1, 32'hCAFE);
        expect_val("byp_next_rd2", SelRd2, 32'hCAFE);
        expect_val("cnt_after_byp", SelCnt, 32'd7);
        strobe();

        // Mid-run reset: immediate clear, with a write attempted throughout.
        set_wr(1'b1, 5'd3, 2'b00, 32'h55);
        ra1 = 5'd7; ra2 = 5'd5;
        reset = 1'b0;
        #1;
        expect_val("rst_r7_now", SelRd1, 32'h0);
        expect_val("rst_r5_now", SelRd2, 32'h0);
        expect_val("rst_cnt_now", SelCnt, 32'h0);
        strobe();
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            expect_val("rst_sweep_rd1", SelRd1, 32'h0);
            expect_val("rst_sweep_rd2", SelRd2, 32'h0);
            strobe();
        end
        tick();
        expect_val("rst_cnt_held", SelCnt, 32'h0);
        strobe();
        reset = 1'b1;
        ra1 = 5'd3; ra2 = 5'd9;
        tick();
        regwrite = 1'b0;
        expect_val("post_rst_r3", SelRd1, 32'h55);
        expect_val("post_rst_r9", SelRd2, 32'h0);
        expect_val("post_rst_cnt", SelCnt, 32'd1);
        strobe();

        // Counter wrap: load all-ones through the next-state net, then one write.
        force dut.retire_d = 32'hFFFFFFFF;
        tick();
        release dut.retire_d;
        expect_val("cnt_preload", SelCnt, 32'hFFFFFFFF);
        strobe();
        set_wr(1'b1, 5'd4, 2'b10, 32'h0);
        ra1 = 5'd4;
        tick();
        regwrite = 1'b0;
        expect_val("cnt_wrap", SelCnt, 32'h0);
        expect_val("r4_pc4", SelRd1, 32'h33);
        strobe();
        regwrite = 1'b1;
        tick();
        regwrite = 1'b0;
        expect_val("cnt_after_wrap", SelCnt, 32'd1);
        strobe();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
